// File: rtl/packet_buffer_arbiter.sv
// Round-robin sharing of the packet buffer RAM driver's read and write ports among NUM_REQ requesters.
// Read results are steered back to their issuer through a grant-tag pipeline that matches the RAM read latency.
module packet_buffer_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_LEN     = 12,
  parameter int WORD_LEN     = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           rd_req,
  input  logic [NUM_REQ*ADDR_LEN-1:0]  rd_addr,
  output logic [NUM_REQ-1:0]           rd_grant,
  output logic [NUM_REQ-1:0]           rd_valid,
  output logic [WORD_LEN-1:0]          rd_data,
  input  logic [NUM_REQ-1:0]           wr_req,
  input  logic [NUM_REQ*ADDR_LEN-1:0]  wr_addr,
  input  logic [NUM_REQ*WORD_LEN-1:0]  wr_val,
  output logic [NUM_REQ-1:0]           wr_grant,
  output logic                         ram_read_req,
  output logic [ADDR_LEN-1:0]          ram_read_addr,
  input  logic                         ram_read_ready,
  input  logic [WORD_LEN-1:0]          ram_read_out,
  output logic                         ram_write_enable,
  output logic [ADDR_LEN-1:0]          ram_write_addr,
  output logic [WORD_LEN-1:0]          ram_write_val
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Returns {found, winner}: first eligible index scanning ptr, ptr+1, ... modulo NUM_REQ.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                             input logic [PTR_W-1:0]   ptr);
    logic             found;
    logic [PTR_W-1:0] win;
    int               idx;
    found = 1'b0;
    win   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    return {found, win};
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] win);
    return (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  endfunction

  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [NUM_REQ-1:0] rd_elig;
  logic [NUM_REQ-1:0] wr_elig;
  logic               rd_any;
  logic               wr_any;
  logic [PTR_W-1:0]   rd_win;
  logic [PTR_W-1:0]   wr_win;
  logic [NUM_REQ-1:0] rd_onehot;
  logic [NUM_REQ-1:0] wr_onehot;

  // Masking the current grant keeps a requester that still holds its request
  // during the grant cycle from being accepted twice.
  assign rd_elig = rd_req & ~rd_grant;
  assign wr_elig = wr_req & ~wr_grant;

  assign {rd_any, rd_win} = rr_pick(rd_elig, rd_ptr_reg);
  assign {wr_any, wr_win} = rr_pick(wr_elig, wr_ptr_reg);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign rd_onehot[gi] = (rd_win == PTR_W'(gi));
      assign wr_onehot[gi] = (wr_win == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_grant      <= '0;
      ram_read_req  <= 1'b0;
      ram_read_addr <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      rd_grant     <= rd_any ? rd_onehot : '0;
      ram_read_req <= rd_any;
      if (rd_any) begin
        ram_read_addr <= rd_addr[int'(rd_win)*ADDR_LEN +: ADDR_LEN];
        rd_ptr_reg    <= next_ptr(rd_win);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_grant         <= '0;
      ram_write_enable <= 1'b0;
      ram_write_addr   <= '0;
      ram_write_val    <= '0;
      wr_ptr_reg       <= '0;
    end else begin
      wr_grant         <= wr_any ? wr_onehot : '0;
      ram_write_enable <= wr_any;
      if (wr_any) begin
        ram_write_addr <= wr_addr[int'(wr_win)*ADDR_LEN +: ADDR_LEN];
        ram_write_val  <= wr_val[int'(wr_win)*WORD_LEN +: WORD_LEN];
        wr_ptr_reg     <= next_ptr(wr_win);
      end
    end
  end

  // Tag pipeline: the last stage lines up with ram_read_ready for the read
  // issued READ_LATENCY cycles earlier; reset drops every in-flight tag.
  logic [NUM_REQ-1:0] tag_pipe [READ_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= rd_grant;
      for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign rd_valid = tag_pipe[READ_LATENCY-1] & {NUM_REQ{ram_read_ready}};
  assign rd_data  = ram_read_out;

endmodule
